// File: rtl/pass_checker.sv
// Keypad password checker: collects DIGITS nibbles, compares against the stored password,
// opens an unlock/update window on a match. Define PASS_CHECKER_LOCKOUT_EN for fail-count lockout.
module pass_checker #(
  parameter int                  DIGITS         = 8,
  parameter logic [4*DIGITS-1:0] DEFAULT_PASS   = 32'h12345678,
  parameter int                  MAX_TRIES      = 3,
  parameter int                  UNLOCK_CYCLES  = 500,
  parameter int                  LOCKOUT_CYCLES = 1000,
  parameter int                  TIMEOUT_CYCLES = 2000
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  keyValid,
  input  logic [3:0]            keyDigit,
  input  logic                  keyClear,
  input  logic [4*DIGITS-1:0]   newPass,
  output logic                  unlockDoor,
  output logic                  keyEnable,
  output logic                  accessDenied,
  output logic                  lockedOut,
  output logic [3:0]            digitCount
);

  localparam int PW     = 4 * DIGITS;
  localparam int M1     = (UNLOCK_CYCLES > TIMEOUT_CYCLES) ? UNLOCK_CYCLES : TIMEOUT_CYCLES;
  localparam int MAXCYC = (M1 > LOCKOUT_CYCLES) ? M1 : LOCKOUT_CYCLES;
  localparam int TW     = $clog2(MAXCYC + 1);

  localparam logic [3:0]    DIG_LAST = 4'(DIGITS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] UNL_LAST = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] KEN_LAST = TW'(UNLOCK_CYCLES - 2);
  localparam logic [TW-1:0] TW_ONE   = TW'(1);

  if (UNLOCK_CYCLES < 3 || MAX_TRIES < 1) begin : gBadParams
    $error("pass_checker: UNLOCK_CYCLES must be >= 3 and MAX_TRIES >= 1");
  end

  typedef enum logic [2:0] {
    IDLE, ENTRY, CHECK, UNLOCK
`ifdef PASS_CHECKER_LOCKOUT_EN
    , LOCKOUT
`endif
  } state_t;

  state_t        state_q;
  logic [PW-1:0] entry_q;
  logic [PW-1:0] storedPass_q;
  logic [3:0]    digitCount_q;
  logic [TW-1:0] timer_q;
  logic          unlockDoor_q;
  logic          keyEnable_q;
  logic          accessDenied_q;
  logic [PW-1:0] entryShift_d;

  assign entryShift_d = {entry_q[PW-5:0], keyDigit};

`ifdef PASS_CHECKER_LOCKOUT_EN
  localparam int            FW        = $clog2(MAX_TRIES + 1);
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_TRIES - 1);
  localparam logic [FW-1:0] FW_ONE    = FW'(1);
  localparam logic [TW-1:0] LCK_LAST  = TW'(LOCKOUT_CYCLES - 1);
  logic          lockedOut_q;
  logic [FW-1:0] failCnt_q;
  assign lockedOut = lockedOut_q;
`else
  assign lockedOut = 1'b0;
`endif

  assign unlockDoor   = unlockDoor_q;
  assign keyEnable    = keyEnable_q;
  assign accessDenied = accessDenied_q;
  assign digitCount   = digitCount_q;

  // timer_q is shared: idle timeout in ENTRY, window position u in UNLOCK, lockout length in LOCKOUT
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= IDLE;
      entry_q        <= '0;
      storedPass_q   <= DEFAULT_PASS;
      digitCount_q   <= '0;
      timer_q        <= '0;
      unlockDoor_q   <= 1'b0;
      keyEnable_q    <= 1'b0;
      accessDenied_q <= 1'b0;
`ifdef PASS_CHECKER_LOCKOUT_EN
      lockedOut_q    <= 1'b0;
      failCnt_q      <= '0;
`endif
    end else begin
      accessDenied_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (keyValid) begin
            entry_q      <= entryShift_d;
            digitCount_q <= 4'd1;
            timer_q      <= '0;
            state_q      <= (DIGITS == 1) ? CHECK : ENTRY;
          end
        end
        ENTRY: begin
          if (keyClear) begin
            entry_q      <= '0;
            digitCount_q <= '0;
            state_q      <= IDLE;
          end else if (keyValid) begin
            entry_q      <= entryShift_d;
            digitCount_q <= digitCount_q + 4'd1;
            timer_q      <= '0;
            if (digitCount_q == DIG_LAST) state_q <= CHECK;
          end else if (timer_q == TMO_LAST) begin
            entry_q      <= '0;
            digitCount_q <= '0;
            state_q      <= IDLE;
          end else begin
            timer_q <= timer_q + TW_ONE;
          end
        end
        CHECK: begin
          entry_q      <= '0;
          digitCount_q <= '0;
          timer_q      <= '0;
          if (entry_q == storedPass_q) begin
`ifdef PASS_CHECKER_LOCKOUT_EN
            failCnt_q <= '0;
`endif
            unlockDoor_q <= 1'b1;
            state_q      <= UNLOCK;
          end else begin
            accessDenied_q <= 1'b1;
`ifdef PASS_CHECKER_LOCKOUT_EN
            failCnt_q <= failCnt_q + FW_ONE;
            if (failCnt_q == FAIL_LAST) begin
              lockedOut_q <= 1'b1;
              state_q     <= LOCKOUT;
            end else begin
              state_q <= IDLE;
            end
`else
            state_q <= IDLE;
`endif
          end
        end
        UNLOCK: begin
          // keyEnable is registered one step ahead so it is high exactly for u in 1..UNLOCK_CYCLES-2
          if (timer_q == UNL_LAST) begin
            unlockDoor_q <= 1'b0;
            keyEnable_q  <= 1'b0;
            storedPass_q <= newPass;
            timer_q      <= '0;
            state_q      <= IDLE;
          end else begin
            timer_q     <= timer_q + TW_ONE;
            keyEnable_q <= (timer_q != KEN_LAST);
          end
        end
`ifdef PASS_CHECKER_LOCKOUT_EN
        LOCKOUT: begin
          if (timer_q == LCK_LAST) begin
            lockedOut_q <= 1'b0;
            failCnt_q   <= '0;
            timer_q     <= '0;
            state_q     <= IDLE;
          end else begin
            timer_q <= timer_q + TW_ONE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pass_checker.sv
// Self-checking bench for pass_checker: directed scenarios plus randomized attempts,
// compared every cycle against a phase/age model of the keypad lock.
module tb_pass_checker;

  localparam int D  = 8;
  localparam int U  = 8;
  localparam int L  = 16;
  localparam int T  = 20;
  localparam int MT = 3;
`ifdef PASS_CHECKER_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        keyValid = 1'b0;
  logic [3:0]  keyDigit = 4'd0;
  logic        keyClear = 1'b0;
  logic [31:0] newPass = 32'h0;
  logic        unlockDoor, keyEnable, accessDenied, lockedOut;
  logic [3:0]  digitCount;

  pass_checker #(
    .DIGITS(D), .DEFAULT_PASS(32'h12345678), .MAX_TRIES(MT),
    .UNLOCK_CYCLES(U), .LOCKOUT_CYCLES(L), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .resetN(resetN), .keyValid(keyValid), .keyDigit(keyDigit),
    .keyClear(keyClear), .newPass(newPass), .unlockDoor(unlockDoor),
    .keyEnable(keyEnable), .accessDenied(accessDenied), .lockedOut(lockedOut),
    .digitCount(digitCount)
  );

  always #5 clk = ~clk;

  int passCount = 0;
  int checkCount = 0;
  bit checkOn = 1'b0;
  int cntUnlock = 0, cntKeyEn = 0, cntDenied = 0, cntLocked = 0;

  // Model: phase 0 idle, 1 typing, 2 judging, 3 door open, 4 locked; age = cycles spent in phase
  int          mPhase, mAge, mSince, mTyped, mFails;
  logic [31:0] mEntry, mStored;
  bit          mDenied;

  task automatic checkOutput(input string name, input int act, input int exp);
    checkCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic modelReset();
    mPhase = 0; mAge = 0; mSince = 0; mTyped = 0; mFails = 0;
    mEntry = 32'h0; mStored = 32'h12345678; mDenied = 1'b0;
  endtask

  task automatic modelStep(input bit kv, input logic [3:0] kd, input bit kc, input logic [31:0] np);
    mDenied = 1'b0;
    case (mPhase)
      0: if (kv) begin
        mEntry = (mEntry << 4) | 32'(kd);
        mTyped = 1; mSince = 0;
        mPhase = (mTyped == D) ? 2 : 1;
      end
      1: if (kc) begin
        mEntry = 0; mTyped = 0; mPhase = 0;
      end else if (kv) begin
        mEntry = (mEntry << 4) | 32'(kd);
        mTyped++; mSince = 0;
        if (mTyped == D) mPhase = 2;
      end else begin
        mSince++;
        if (mSince == T) begin mEntry = 0; mTyped = 0; mPhase = 0; end
      end
      2: begin
        if (mEntry == mStored) begin
          mFails = 0; mPhase = 3; mAge = 0;
        end else begin
          mDenied = 1'b1; mFails++;
          if (LOCK_EN && mFails == MT) begin mPhase = 4; mAge = 0; end
          else mPhase = 0;
        end
        mEntry = 0; mTyped = 0;
      end
      3: if (mAge == U - 1) begin mStored = np; mPhase = 0; end else mAge++;
      4: if (mAge == L - 1) begin mFails = 0; mPhase = 0; end else mAge++;
      default: mPhase = 0;
    endcase
  endtask

  always @(negedge clk) begin
    if (checkOn && resetN) begin
      checkOutput("unlockDoor", int'(unlockDoor), int'(mPhase == 3));
      checkOutput("keyEnable", int'(keyEnable), int'(mPhase == 3 && mAge >= 1 && mAge <= U - 2));
      checkOutput("accessDenied", int'(accessDenied), int'(mDenied));
      checkOutput("lockedOut", int'(lockedOut), int'(mPhase == 4));
      checkOutput("digitCount", int'(digitCount), mTyped);
      cntUnlock += int'(unlockDoor);
      cntKeyEn  += int'(keyEnable);
      cntDenied += int'(accessDenied);
      cntLocked += int'(lockedOut);
    end
  end

  task automatic applyStimulus(input bit kv, input logic [3:0] kd, input bit kc);
    keyValid = kv; keyDigit = kd; keyClear = kc;
    @(posedge clk);
    modelStep(kv, kd, kc, newPass);
    #1;
    keyValid = 1'b0; keyClear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 1'b0);
  endtask

  task automatic sendCode(input logic [31:0] code);
    for (int i = D - 1; i >= 0; i--) applyStimulus(1'b1, code[4*i +: 4], 1'b0);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 100 && mPhase != 0; i++) idle(1);
    if (mPhase != 0) checkOutput("waitIdle_bound", mPhase, 0);
  endtask

  task automatic resetTallies();
    cntUnlock = 0; cntKeyEn = 0; cntDenied = 0; cntLocked = 0;
  endtask

  initial begin
    int kind, k;
    logic [31:0] code;
    modelReset();
    #3;
    checkOutput("reset_unlockDoor", int'(unlockDoor), 0);
    checkOutput("reset_keyEnable", int'(keyEnable), 0);
    checkOutput("reset_accessDenied", int'(accessDenied), 0);
    checkOutput("reset_lockedOut", int'(lockedOut), 0);
    checkOutput("reset_digitCount", int'(digitCount), 0);
    #9;
    resetN = 1'b1;
    checkOn = 1'b1;
    idle(2);

    $display("[TB] default password unlock");
    newPass = 32'hCAFEF00D;
    resetTallies();
    sendCode(32'h12345678);
    checkOutput("unlock_not_yet", int'(unlockDoor), 0);
    idle(1);
    checkOutput("unlock_2edges", int'(unlockDoor), 1);
    checkOutput("keyEnable_lags", int'(keyEnable), 0);
    idle(11);
    checkOutput("unlock_len", cntUnlock, 8);
    checkOutput("keyEnable_len", cntKeyEn, 6);

    $display("[TB] new password takes effect, old one refused");
    resetTallies();
    sendCode(32'hCAFEF00D);
    idle(12);
    checkOutput("newpass_unlock", cntUnlock, 8);
    resetTallies();
    sendCode(32'h12345678);
    idle(3);
    checkOutput("oldpass_unlock", cntUnlock, 0);
    checkOutput("oldpass_denied", cntDenied, 1);
    newPass = 32'h12345678;
    sendCode(32'hCAFEF00D);
    idle(12);

    $display("[TB] three wrong attempts");
    resetTallies();
    for (int a = 0; a < 3; a++) begin
      sendCode(32'h87654321);
      idle(2);
    end
    applyStimulus(1'b1, 4'h9, 1'b0);
    applyStimulus(1'b1, 4'h9, 1'b0);
    applyStimulus(1'b1, 4'h9, 1'b0);
    if (LOCK_EN) checkOutput("lockout_keys_ignored", int'(digitCount), 0);
    idle(30);
    checkOutput("wrong_denied", cntDenied, 3);
    checkOutput("lockout_len", cntLocked, LOCK_EN ? 16 : 0);
    resetTallies();
    sendCode(32'h12345678);
    idle(12);
    checkOutput("after_lockout_unlock", cntUnlock, 8);

    $display("[TB] clear wins over key");
    resetTallies();
    applyStimulus(1'b1, 4'h1, 1'b0);
    applyStimulus(1'b1, 4'h2, 1'b0);
    applyStimulus(1'b1, 4'h3, 1'b0);
    applyStimulus(1'b1, 4'h4, 1'b1);
    checkOutput("clear_digitCount", int'(digitCount), 0);
    sendCode(32'h12345678);
    idle(12);
    checkOutput("after_clear_unlock", cntUnlock, 8);

    $display("[TB] entry timeout");
    resetTallies();
    applyStimulus(1'b1, 4'h1, 1'b0);
    applyStimulus(1'b1, 4'h2, 1'b0);
    idle(T + 2);
    checkOutput("timeout_digitCount", int'(digitCount), 0);
    checkOutput("timeout_no_denied", cntDenied, 0);
    sendCode(32'h11111111);
    idle(2);
    sendCode(32'h22222222);
    idle(2);
    sendCode(32'h12345678);
    idle(12);
    checkOutput("two_wrong_denied", cntDenied, 2);
    checkOutput("two_wrong_no_lock", cntLocked, 0);
    checkOutput("two_wrong_then_unlock", cntUnlock, 8);

    $display("[TB] randomized attempts");
    for (int a = 0; a < 60; a++) begin
      newPass = $urandom;
      if ($urandom_range(0, 3) != 0) waitIdle();
      kind = $urandom_range(0, 4);
      code = (kind <= 1) ? mStored : $urandom;
      k = (kind >= 3) ? $urandom_range(1, D - 1) : D;
      for (int i = D - 1; i >= D - k; i--) begin
        applyStimulus(1'b1, code[4*i +: 4], 1'b0);
        idle($urandom_range(0, 2));
      end
      if (kind == 3) applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), 1'b1);
      if (kind == 4) idle($urandom_range(T - 2, T + 1));
    end
    waitIdle();

    $display("[TB] reset during unlock window");
    newPass = 32'hDEADBEEF;
    sendCode(mStored);
    idle(5);
    checkOutput("prerst_unlockDoor", int'(unlockDoor), 1);
    checkOutput("prerst_keyEnable", int'(keyEnable), 1);
    #2;
    checkOn = 1'b0;
    resetN = 1'b0;
    #1;
    checkOutput("rst_unlockDoor", int'(unlockDoor), 0);
    checkOutput("rst_keyEnable", int'(keyEnable), 0);
    modelReset();
    @(negedge clk);
    #1;
    resetN = 1'b1;
    checkOn = 1'b1;
    resetTallies();
    sendCode(32'h12345678);
    idle(12);
    checkOutput("rst_default_pass", cntUnlock, 8);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
